// File: rtl/ram_port_arbiter_if.sv
// Requester and RAM-side bus of the RAM port arbiter.
// master: the requesters and the RAM (drive requests and read data).
// slave:  the arbiter (serves requests and drives the RAM strobes).
interface ram_port_arbiter_if #(
   parameter int NPORT = 2
);
   logic [NPORT-1:0]      req_valid;
   logic [NPORT-1:0]      req_wr;
   logic [3*NPORT-1:0]    req_width;
   logic [32*NPORT-1:0]   req_addr;
   logic [32*NPORT-1:0]   req_wdata;
   logic [NPORT-1:0]      resp_done;
   logic [32*NPORT-1:0]   resp_rdata;
   logic [7:0]            ram_din;
   logic [7:0]            ram_dout;
   logic [31:0]           ram_a;
   logic                  ram_wr;

   modport master (
      output req_valid, req_wr, req_width, req_addr, req_wdata, ram_din,
      input  resp_done, resp_rdata, ram_dout, ram_a, ram_wr
   );

   modport slave (
      input  req_valid, req_wr, req_width, req_addr, req_wdata, ram_din,
      output resp_done, resp_rdata, ram_dout, ram_a, ram_wr
   );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter that serialises byte-wide RAM accesses for NPORT
// requesters. Multi-byte loads/stores are split into one byte per cycle;
// stores into the IO region (addr[17:16] == 2'b11) are throttled by the
// IO sink full flag and spaced IO_GAP idle cycles apart.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | no operation; pick the next valid port round-robin
// ST_READ   | issuing read addresses / capturing bytes, k = byte index
// ST_WRITE  | issuing write byte k (IO bytes wait for sink not full)
// ST_IOWAIT | enforced idle gap after an IO-region byte write
module ram_port_arbiter #(
   parameter int               NPORT      = 2,
   parameter int               IO_GAP     = 3,
   parameter logic [NPORT-1:0] FLUSH_MASK = {NPORT{1'b1}}
) (
   input  logic clk_in,
   input  logic rst_in,
   input  logic flush_in,
   input  logic hci_if_full,
   output logic busy,
   ram_port_arbiter_if.slave bus
);

   localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;
   localparam int CW = PW + 1;
   localparam int GW = (IO_GAP > 1) ? $clog2(IO_GAP) : 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_READ   = 2'd1,
      ST_WRITE  = 2'd2,
      ST_IOWAIT = 2'd3
   } state_t;

   state_t          state_q;
   state_t          state_nxt;

   logic [2:0]      k_q;
   logic [2:0]      k_nxt;
   logic [GW-1:0]   gap_q;
   logic [GW-1:0]   gap_nxt;
   logic [PW-1:0]   rr_q;
   logic [PW-1:0]   gnt_q;
   logic [2:0]      width_q;
   logic [31:0]     addr_q;
   logic [31:0]     wdata_q;
   logic [31:0]     rbuf_q;
   logic [31:0]     rbuf_nxt;
   logic [31:0]     rdata_q [NPORT];

   logic [2:0]      width_arr [NPORT];
   logic [31:0]     addr_arr  [NPORT];
   logic [31:0]     wdata_arr [NPORT];

   logic            gnt_found;
   logic [PW-1:0]   gnt_idx;
   logic [CW-1:0]   cand;

   logic            grant;
   logic            done_set;
   logic            rdata_set;
   logic            cap_en;
   logic            width_ok;
   logic            is_io;
   logic            issue;
   logic            last;
   logic [4:0]      boff_r;
   logic [4:0]      boff_w;

   // Unpack the flat per-port request buses and pack the per-port load data.
   always_comb begin
      for (int i = 0; i < NPORT; i++) begin
         width_arr[i] = bus.req_width[3*i +: 3];
         addr_arr[i]  = bus.req_addr[32*i +: 32];
         wdata_arr[i] = bus.req_wdata[32*i +: 32];
         bus.resp_rdata[32*i +: 32] = rdata_q[i];
      end
   end

   // Round-robin search: first valid port at or above rr_q, wrapping at NPORT.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      for (int i = 0; i < NPORT; i++) begin
         cand = {1'b0, rr_q} + CW'(i);
         if (cand >= CW'(NPORT)) begin
            cand = cand - CW'(NPORT);
         end
         if (!gnt_found && bus.req_valid[cand[PW-1:0]]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand[PW-1:0];
         end
      end
   end

   // Operation qualifiers derived from the latched request.
   always_comb begin
      width_ok = (width_q == 3'd1) || (width_q == 3'd2) || (width_q == 3'd4);
      is_io    = (addr_q[17:16] == 2'b11);
      last     = (k_q == (width_q - 3'd1));
      issue    = (state_q == ST_WRITE) && width_ok && (k_q < width_q) &&
                 (!is_io || !hci_if_full);
      boff_r   = {k_q[1:0] - 2'd1, 3'b000};
      boff_w   = {k_q[1:0], 3'b000};
   end

   // State register.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_nxt;
      end
   end

   // Next-state logic and per-cycle control strobes.
   always_comb begin
      state_nxt = state_q;
      k_nxt     = k_q;
      gap_nxt   = gap_q;
      grant     = 1'b0;
      done_set  = 1'b0;
      rdata_set = 1'b0;
      cap_en    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (!flush_in && gnt_found) begin
               grant     = 1'b1;
               k_nxt     = '0;
               state_nxt = bus.req_wr[gnt_idx] ? ST_WRITE : ST_READ;
            end
         end
         ST_READ: begin
            if (flush_in && FLUSH_MASK[gnt_q]) begin
               k_nxt     = '0;
               state_nxt = ST_IDLE;
            end else if (!width_ok) begin
               // rbuf was cleared at grant, so this loads zero
               done_set  = 1'b1;
               rdata_set = 1'b1;
               state_nxt = ST_IDLE;
            end else begin
               cap_en = (k_q != 3'd0);
               if (k_q == width_q) begin
                  done_set  = 1'b1;
                  rdata_set = 1'b1;
                  k_nxt     = '0;
                  state_nxt = ST_IDLE;
               end else begin
                  k_nxt = k_q + 3'd1;
               end
            end
         end
         ST_WRITE: begin
            if (!width_ok) begin
               done_set  = 1'b1;
               rdata_set = 1'b1;
               state_nxt = ST_IDLE;
            end else if (issue) begin
               k_nxt = k_q + 3'd1;
               if (is_io && (IO_GAP > 0)) begin
                  // the gap also follows the last IO byte, so back-to-back
                  // IO stores from different requests stay spaced
                  gap_nxt   = GW'(IO_GAP - 1);
                  state_nxt = ST_IOWAIT;
               end else if (last) begin
                  done_set  = 1'b1;
                  k_nxt     = '0;
                  state_nxt = ST_IDLE;
               end
            end
         end
         ST_IOWAIT: begin
            if (gap_q == '0) begin
               if (k_q == width_q) begin
                  done_set  = 1'b1;
                  k_nxt     = '0;
                  state_nxt = ST_IDLE;
               end else begin
                  state_nxt = ST_WRITE;
               end
            end else begin
               gap_nxt = gap_q - GW'(1);
            end
         end
      endcase
   end

   // Load assembly: byte k-1 arrives on ram_din while k is presented.
   always_comb begin
      rbuf_nxt = rbuf_q;
      if (cap_en) begin
         rbuf_nxt[boff_r +: 8] = bus.ram_din;
      end
   end

   // Datapath: request latch, byte counter, gap timer, round-robin pointer, responses.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         k_q           <= '0;
         gap_q         <= '0;
         rr_q          <= '0;
         gnt_q         <= '0;
         width_q       <= '0;
         addr_q        <= '0;
         wdata_q       <= '0;
         rbuf_q        <= '0;
         bus.resp_done <= '0;
         for (int i = 0; i < NPORT; i++) begin
            rdata_q[i] <= '0;
         end
      end else begin
         k_q           <= k_nxt;
         gap_q         <= gap_nxt;
         bus.resp_done <= '0;
         if (grant) begin
            gnt_q   <= gnt_idx;
            rr_q    <= (gnt_idx == PW'(NPORT - 1)) ? '0 : gnt_idx + PW'(1);
            width_q <= width_arr[gnt_idx];
            addr_q  <= addr_arr[gnt_idx];
            wdata_q <= wdata_arr[gnt_idx];
            rbuf_q  <= '0;
         end else begin
            rbuf_q <= rbuf_nxt;
         end
         if (done_set) begin
            bus.resp_done[gnt_q] <= 1'b1;
         end
         if (rdata_set) begin
            rdata_q[gnt_q] <= rbuf_nxt;
         end
      end
   end

   // RAM strobes; write enable is also gated by reset so it drops without a clock.
   always_comb begin
      bus.ram_a    = '0;
      bus.ram_wr   = 1'b0;
      bus.ram_dout = '0;
      if ((state_q == ST_READ) && width_ok && (k_q < width_q)) begin
         bus.ram_a = addr_q + 32'(k_q);
      end
      if (issue && !rst_in) begin
         bus.ram_wr   = 1'b1;
         bus.ram_a    = addr_q + 32'(k_q);
         bus.ram_dout = wdata_q[boff_w +: 8];
      end
   end

   assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: reset, multi-byte read, round-robin
// fairness, IO-throttled write, flush abort, illegal width, plain write,
// and asynchronous reset during a write.
module tb_ram_port_arbiter;

   logic clk_in;
   logic rst_in;
   logic flush_in;
   logic hci_if_full;
   logic busy;

   ram_port_arbiter_if #(.NPORT(2)) bus ();

   ram_port_arbiter #(.NPORT(2), .IO_GAP(3), .FLUSH_MASK(2'b11)) dut (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .flush_in    (flush_in),
      .hci_if_full (hci_if_full),
      .busy        (busy),
      .bus         (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int done_cnt [2];
   int ovl_cnt = 0;
   int wr_cyc [$];
   logic [31:0] wr_addr [$];
   logic [7:0]  wr_data [$];
   logic [7:0]  mem [bit [31:0]];

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   always @(posedge clk_in) cyc <= cyc + 1;

   // Byte RAM: read data valid one cycle after the address.
   always @(posedge clk_in) begin
      bus.ram_din <= mem.exists(bus.ram_a) ? mem[bus.ram_a] : 8'h00;
   end

   // Observe done pulses and write strobes mid-cycle.
   always @(negedge clk_in) begin
      if (!rst_in) begin
         if (bus.resp_done[0]) done_cnt[0] = done_cnt[0] + 1;
         if (bus.resp_done[1]) done_cnt[1] = done_cnt[1] + 1;
         if ($countones(bus.resp_done) > 1) ovl_cnt = ovl_cnt + 1;
         if (bus.ram_wr) begin
            wr_cyc.push_back(cyc);
            wr_addr.push_back(bus.ram_a);
            wr_data.push_back(bus.ram_dout);
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic set_req(input int p, input logic wr, input logic [2:0] w,
                          input logic [31:0] a, input logic [31:0] d);
      bus.req_wr[p]           = wr;
      bus.req_width[3*p +: 3] = w;
      bus.req_addr[32*p +: 32]  = a;
      bus.req_wdata[32*p +: 32] = d;
      bus.req_valid[p]        = 1'b1;
   endtask

   function automatic logic [31:0] rdata(input int p);
      return bus.resp_rdata[32*p +: 32];
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n;
      int g;
      int w0;
      int d0;
      int d1;
      int c0;
      int c1;
      int order [$];
      int exp_ord [4];

      exp_ord = '{0, 1, 0, 1};
      done_cnt[0] = 0;
      done_cnt[1] = 0;
      rst_in = 1'b1;
      flush_in = 1'b0;
      hci_if_full = 1'b0;
      bus.req_valid = '0;
      bus.req_wr = '0;
      bus.req_width = '0;
      bus.req_addr = '0;
      bus.req_wdata = '0;
      mem[32'h100] = 8'h11;
      mem[32'h101] = 8'h22;
      mem[32'h102] = 8'h33;
      mem[32'h103] = 8'h44;
      mem[32'h200] = 8'h5A;
      mem[32'h300] = 8'hA5;

      // reset values
      #2;
      chk("rst_busy", busy, 0);
      chk("rst_ram_wr", bus.ram_wr, 0);
      chk("rst_ram_a", bus.ram_a, 0);
      chk("rst_ram_dout", bus.ram_dout, 0);
      chk("rst_done", bus.resp_done, 0);
      chk("rst_rdata0", rdata(0), 0);
      tick();
      tick();
      rst_in = 1'b0;
      tick();

      // port0 4-byte read at 0x100
      set_req(0, 1'b0, 3'd4, 32'h100, 32'h0);
      tick();
      chk("rd4_busy", busy, 1);
      n = 0;
      while (!bus.resp_done[0] && n < 20) begin
         tick();
         n++;
      end
      chk("rd4_latency", n, 5);
      chk("rd4_data", rdata(0), 32'h44332211);
      bus.req_valid[0] = 1'b0;
      tick();
      chk("rd4_done_pulse", bus.resp_done, 0);
      chk("rd4_idle", busy, 0);

      // reset clears load data and pointer, then both ports request twice
      rst_in = 1'b1;
      #1;
      chk("rst2_rdata0", rdata(0), 0);
      tick();
      rst_in = 1'b0;
      set_req(0, 1'b0, 3'd1, 32'h200, 32'h0);
      set_req(1, 1'b0, 3'd1, 32'h300, 32'h0);
      c0 = 0;
      c1 = 0;
      n = 0;
      while (order.size() < 4 && n < 60) begin
         tick();
         n++;
         if (bus.resp_done[0]) begin
            order.push_back(0);
            c0++;
            if (c0 == 2) bus.req_valid[0] = 1'b0;
         end
         if (bus.resp_done[1]) begin
            order.push_back(1);
            c1++;
            if (c1 == 2) bus.req_valid[1] = 1'b0;
         end
      end
      bus.req_valid = '0;
      chk("rr_count", order.size(), 4);
      for (int i = 0; i < 4 && i < order.size(); i++) begin
         chk($sformatf("rr_order%0d", i), order[i], exp_ord[i]);
      end
      chk("rr_rdata0", rdata(0), 32'h5A);
      chk("rr_rdata1", rdata(1), 32'hA5);
      tick();

      // port1 IO write, sink full for the first two write cycles
      w0 = wr_cyc.size();
      d1 = done_cnt[1];
      hci_if_full = 1'b1;
      set_req(1, 1'b1, 3'd2, 32'h30000, 32'hBEEF);
      tick();
      g = cyc;
      tick();
      tick();
      hci_if_full = 1'b0;
      n = 0;
      while (!bus.resp_done[1] && n < 30) begin
         tick();
         n++;
      end
      bus.req_valid[1] = 1'b0;
      chk("io_done_cyc", cyc - g, 10);
      chk("io_nwrites", wr_cyc.size() - w0, 2);
      if (wr_cyc.size() >= w0 + 2) begin
         chk("io_b0_data", wr_data[w0], 8'hEF);
         chk("io_b0_addr", wr_addr[w0], 32'h30000);
         chk("io_b0_cyc", wr_cyc[w0] - g, 2);
         chk("io_b1_data", wr_data[w0+1], 8'hBE);
         chk("io_b1_addr", wr_addr[w0+1], 32'h30001);
         chk("io_gap", wr_cyc[w0+1] - wr_cyc[w0], 4);
      end
      tick();
      chk("io_single_done", done_cnt[1] - d1, 1);

      // flush during port0 read at k=2
      d0 = done_cnt[0];
      set_req(0, 1'b0, 3'd4, 32'h100, 32'h0);
      tick();
      tick();
      tick();
      flush_in = 1'b1;
      bus.req_valid[0] = 1'b0;
      tick();
      flush_in = 1'b0;
      chk("fl_busy", busy, 0);
      chk("fl_done", bus.resp_done, 0);
      tick();
      tick();
      chk("fl_no_done", done_cnt[0] - d0, 0);
      chk("fl_rdata0", rdata(0), 32'h5A);

      // illegal width: read on port0, write on port1
      w0 = wr_cyc.size();
      set_req(0, 1'b0, 3'd3, 32'h100, 32'h0);
      tick();
      chk("w3r_nodone", bus.resp_done, 0);
      chk("w3r_ram_a", bus.ram_a, 0);
      tick();
      chk("w3r_done", bus.resp_done, 2'b01);
      chk("w3r_rdata", rdata(0), 0);
      bus.req_valid[0] = 1'b0;
      tick();
      chk("w3r_pulse", bus.resp_done, 0);
      set_req(1, 1'b1, 3'd3, 32'h500, 32'h11223344);
      tick();
      chk("w3w_ram_wr", bus.ram_wr, 0);
      tick();
      chk("w3w_done", bus.resp_done, 2'b10);
      chk("w3w_rdata", rdata(1), 0);
      bus.req_valid[1] = 1'b0;
      tick();
      chk("w3_nowrites", wr_cyc.size() - w0, 0);

      // plain 2-byte write, done in the cycle after the last byte
      set_req(0, 1'b1, 3'd2, 32'h500, 32'hCAFE);
      tick();
      chk("wr_b0_wr", bus.ram_wr, 1);
      chk("wr_b0_addr", bus.ram_a, 32'h500);
      chk("wr_b0_data", bus.ram_dout, 8'hFE);
      tick();
      chk("wr_b1_addr", bus.ram_a, 32'h501);
      chk("wr_b1_data", bus.ram_dout, 8'hCA);
      tick();
      chk("wr_done", bus.resp_done, 2'b01);
      chk("wr_end_wr", bus.ram_wr, 0);
      chk("wr_end_dout", bus.ram_dout, 0);
      bus.req_valid[0] = 1'b0;
      tick();

      // asynchronous reset in the middle of a 4-byte write
      d0 = done_cnt[0];
      set_req(0, 1'b1, 3'd4, 32'h400, 32'h12345678);
      tick();
      chk("rw_b0_data", bus.ram_dout, 8'h78);
      tick();
      chk("rw_b1_addr", bus.ram_a, 32'h401);
      chk("rw_b1_wr", bus.ram_wr, 1);
      #2;
      rst_in = 1'b1;
      #1;
      chk("rw_async_wr", bus.ram_wr, 0);
      chk("rw_busy", busy, 0);
      chk("rw_ram_a", bus.ram_a, 0);
      chk("rw_dout", bus.ram_dout, 0);
      chk("rw_done", bus.resp_done, 0);
      bus.req_valid[0] = 1'b0;
      tick();
      tick();
      rst_in = 1'b0;
      tick();
      tick();
      chk("rw_no_done", done_cnt[0] - d0, 0);
      chk("rw_idle", busy, 0);
      chk("done_overlap", ovl_cnt, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 SHALL have parameter NPORT, default 2: number of requester ports, range 1..8.
REQ-002 SHALL have parameter IO_GAP, default 3: idle cycles required between consecutive IO-region byte writes.
REQ-003 SHALL have parameter FLUSH_MASK, default {NPORT{1'b1}}: ports whose in-flight reads a flush cancels.
REQ-004 clk_in  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_in  input  1  reset, asynchronous, active-high.
REQ-006 flush_in  input  1  pipeline flush (jump); cancels reads per FLUSH_MASK.
REQ-007 req_valid  input  NPORT  per-port request; held until that port's resp_done.
REQ-008 req_wr  input  NPORT  per-port 1=write, 0=read.
REQ-009 req_width  input  3*NPORT  per-port byte count; legal values 1, 2, 4.
REQ-010 req_addr  input  32*NPORT  per-port byte address.
REQ-011 req_wdata  input  32*NPORT  per-port store data; byte k = bits [8k+7:8k].
REQ-012 resp_done  output  NPORT  one-cycle completion pulse for the served port.
REQ-013 resp_rdata  output  32*NPORT  per-port load data, zero-extended, held until next done on that port.
REQ-014 busy  output  1  high whenever state is not IDLE.
REQ-015 ram_din  input  8  RAM read byte, valid one cycle after ram_a.
REQ-016 ram_dout  output  8  RAM write byte.
REQ-017 ram_a  output  32  RAM byte address.
REQ-018 ram_wr  output  1  1=write, 0=read.
REQ-019 hci_if_full  input  1  IO sink full; blocks IO-region writes.

Function
REQ-020 SHALL implement FSM states IDLE, READ, WRITE, IOWAIT.
REQ-021 In IDLE with flush_in=0, SHALL grant one valid port round-robin, searching from rr_ptr upward mod NPORT, and latch its addr, width, wdata and wr.
REQ-022 After grant g, SHALL set rr_ptr = (g+1) mod NPORT; rr_ptr resets to 0.
REQ-023 On grant SHALL go to READ if wr=0, else WRITE, with byte counter k=0.
REQ-024 READ: for k<W SHALL drive ram_a=addr+k (mod 2^32) with ram_wr=0; at each edge with k>=1 SHALL capture ram_din into byte k-1; k increments each cycle.
REQ-025 READ at k=W: SHALL capture the last byte, pulse resp_done[g], update resp_rdata[g] and return to IDLE; done is visible W+1 cycles after the grant edge.
REQ-026 WRITE, non-IO address (addr[17:16]!=2'b11): SHALL drive ram_a=addr+k, ram_dout=byte k and ram_wr=1 for k=0..W-1, one byte per cycle.
REQ-027 After the last non-IO write byte, SHALL pulse resp_done[g] in the next cycle and return to IDLE.
REQ-028 WRITE, IO address: a byte SHALL issue only in a cycle with hci_if_full=0; when full, ram_wr=0 and k holds.
REQ-029 After each IO byte, SHALL enter IOWAIT for IO_GAP cycles with ram_wr=0, then return to WRITE for the next byte.
REQ-030 Outside WRITE byte-issue cycles, ram_wr SHALL be 0 and ram_dout SHALL be 0.
REQ-031 Illegal width (not 1, 2 or 4): SHALL make no RAM access, pulse resp_done[g] the cycle after grant, and set resp_rdata[g]=0.
REQ-032 flush_in=1 during READ for a port in FLUSH_MASK: SHALL abort to IDLE with no resp_done and resp_rdata unchanged.
REQ-033 flush_in SHALL never abort WRITE or IOWAIT.
REQ-034 flush_in=1 in IDLE: no grant that cycle; flush takes priority over pending requests.
REQ-035 resp_done SHALL be one-hot or zero at all times.
REQ-036 A port deasserting req_valid mid-service SHALL NOT alter the latched operation.

Reset
REQ-037 While rst_in=1, SHALL hold: state=IDLE, k=0, rr_ptr=0, resp_done=0, resp_rdata=0, busy=0, ram_wr=0, ram_a=0, ram_dout=0.
REQ-038 Reset asserted mid-operation SHALL force ram_wr=0 immediately, without waiting for a clock edge, and drop the operation with no done.

Verification
REQ-039 Port0 read, width 4, addr 0x100, RAM bytes 11,22,33,44 -> resp_done[0] 5 cycles after grant, resp_rdata[0]=0x44332211.
REQ-040 Ports 0 and 1 both request in the same cycle, twice in succession -> grant order 0,1,0,1; no done overlap.
REQ-041 Port1 write, width 2, addr 0x30000, data 0xBEEF, hci_if_full high for 2 cycles -> bytes EF then BE written, 3 idle cycles between them, single done.
REQ-042 flush_in pulse during port0 read at k=2 -> no resp_done[0], busy=0 next cycle, resp_rdata[0] unchanged.
REQ-043 Width 3 request -> no ram_wr, resp_done the cycle after grant, rdata=0.
REQ-044 rst_in asserted mid-write -> ram_wr=0 asynchronously; all outputs at reset values.
